serial_ck: RTL and testbench
============================

SERIAL_CK -- requirements
Module: serial_ck

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all registers.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 cnt  input  32  external free-running count; 0 means idle/restart, each change means one step.
REQ-005 y0  input  1  idle/start level of y.
REQ-006 ncyc  input  8  frame length in steps; 0 means disabled.
REQ-007 n0  input  32  phase of first y toggle.
REQ-008 n1  input  32  phase of second y toggle.
REQ-009 n2  input  32  phase of third y toggle.
REQ-010 ack  output  1  one-cycle pulse at each completed frame.
REQ-011 y  output  1  serial clock waveform.
REQ-012 Inputs y0, ncyc, n0, n1 and n2 SHALL be treated as quasi-static, sampled every cycle with no capture register.

Function
REQ-013 Internal registers SHALL be cnt_q (32 b, previous cnt) and ph (8 b, phase within frame); cnt_q <= cnt every non-reset cycle.
REQ-014 If cnt == 0: ph <= 0 and ack <= 0.
REQ-015 Else if cnt != cnt_q (a step): ph <= 0 when ph >= ncyc-1, else ph+1.
REQ-016 On a step that wraps ph to 0, ack <= 1 for exactly that one cycle; otherwise ack <= 0.
REQ-017 Else (cnt unchanged, nonzero): ph and y hold, and ack <= 0.
REQ-018 y SHALL be combinational from ph: y = y0 XOR (ph >= n0) XOR (ph >= n1) XOR (ph >= n2).
REQ-019 Comparisons SHALL be unsigned with ph zero-extended to 32 b; any nk >= ncyc never toggles.
REQ-020 Latency SHALL be 1 cycle from cnt change to y/ack response.
REQ-021 Threshold order is not required; equal thresholds cancel pairwise per REQ-018, so n0 = n1 gives no net toggle at that phase.
REQ-022 With ncyc = 0, ph SHALL stay 0, y = y0 XOR (0 >= n0) XOR (0 >= n1) XOR (0 >= n2), and ack = 0.
REQ-023 A cnt jump of more than 1 SHALL still count as a single step; cnt wrapping 0xFFFFFFFF to 0 SHALL restart ph at 0 with no ack.
REQ-024 A change of ncyc mid-frame SHALL take effect at the next step; if ph >= ncyc-1 the next step wraps.

Reset
REQ-025 While rst = 1 at a rising edge: ph <= 0, cnt_q <= 0, ack <= 0; y then equals the REQ-018 value at ph = 0.
REQ-026 Reset SHALL take priority over all other updates, including mid-frame; the frame restarts cleanly on release.

Structure
REQ-027 A shared package serial_ck_pkg SHALL hold the width constants CNT_W = 32 and PH_W = 8.
REQ-028 One sub-module, serial_ck_phase, SHALL contain cnt_q, ph and the ack wrap logic; the top level SHALL contain the y toggle logic.

Verification
REQ-029 ncyc=16, n0=2, n1=3, n2=4, y0=1, rst high 10 cycles then cnt held 0 for 20 cycles -> y=1, ack=0 throughout.
REQ-030 Same settings, cnt increments by 1 per cycle -> y per phase: ph0-1 = 1, ph2 = 0, ph3 = 1, ph4-15 = 0; repeats every 16 cycles.
REQ-031 Same run -> ack high for exactly one cycle, the cycle after cnt = 16, 32, 48...; low otherwise.
REQ-032 n0=1, other settings as REQ-030 -> ph0 = 1, ph1-2 = 0, ph3 = 1, ph4-15 = 0.
REQ-033 cnt held at 5 for 3 cycles -> y and ph frozen, no ack; cnt then jumps to 0 -> ph = 0 and y = 1 next cycle.
REQ-034 rst asserted at ph = 9 -> next cycle ph = 0, ack = 0, y = 1; with ncyc = 0 -> ack never asserts.

Source files
------------

// File: rtl/serial_ck_pkg.sv
// Shared widths and helpers for the serial clock generator.
package serial_ck_pkg;

  localparam int CNT_W = 32;
  localparam int PH_W  = 8;

  // True once the phase has reached or passed a toggle threshold.
  // The phase is zero-extended so the comparison is unsigned at full count
  // width. A threshold beyond the frame length is therefore never reached.
  function automatic logic at_or_past(input logic [PH_W-1:0]  ph,
                                      input logic [CNT_W-1:0] thr);
    logic [CNT_W-1:0] ph_ext;
    ph_ext = {{(CNT_W - PH_W){1'b0}}, ph};
    return (ph_ext >= thr);
  endfunction

endpackage

// File: rtl/serial_ck_phase.sv
// Phase tracker: follows the external count and advances the in-frame
// phase once per count change. It emits a one-cycle ack when a frame
// completes.
//
// There is no valid/ready handshake. Any change of cnt is one step,
// however large the jump. cnt == 0 is an idle/restart level that holds
// the phase at 0.
module serial_ck_phase
  import serial_ck_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic [PH_W-1:0]  ncyc,
  output logic [PH_W-1:0]  ph,
  output logic             ack
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PH_W-1:0]  ph_q,  ph_d;
  logic             ack_q, ack_d;

  logic             step;
  logic             disabled;
  logic             last_phase;

  // Step detection and frame-end qualification.
  always_comb begin
    step       = (cnt != cnt_q);
    disabled   = (ncyc == '0);
    // ncyc is re-read every cycle, so a shortened frame wraps on the very
    // next step when the phase is already at or past the new end.
    last_phase = !disabled && (ph_q >= (ncyc - 8'd1));
  end

  // Next-state for the previous count, the phase and the ack pulse.
  always_comb begin
    cnt_d = cnt;
    ph_d  = ph_q;
    ack_d = 1'b0;
    if (cnt == '0) begin
      ph_d = '0;
    end else if (step) begin
      if (disabled) begin
        ph_d = '0;
      end else if (last_phase) begin
        ph_d  = '0;
        ack_d = 1'b1;
      end else begin
        ph_d = ph_q + 8'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ph_q  <= '0;
      ack_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
      ack_q <= ack_d;
    end
  end

  assign ph  = ph_q;
  assign ack = ack_q;

endmodule

// File: rtl/serial_ck.sv
// Serial clock waveform generator. The y output toggles at up to three
// programmable phases within a frame. The frame is stepped by an external
// free-running count.
module serial_ck
  import serial_ck_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             y0,
  input  logic [PH_W-1:0]  ncyc,
  input  logic [CNT_W-1:0] n0,
  input  logic [CNT_W-1:0] n1,
  input  logic [CNT_W-1:0] n2,
  output logic             ack,
  output logic             y
);

  logic [PH_W-1:0] ph;

  serial_ck_phase u_phase (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .ncyc (ncyc),
    .ph   (ph),
    .ack  (ack)
  );

  // Waveform: each threshold passed flips y. Equal thresholds cancel out.
  always_comb begin
    y = y0 ^ at_or_past(ph, n0) ^ at_or_past(ph, n1) ^ at_or_past(ph, n2);
  end

endmodule

// File: tb/tb_serial_ck.sv
// Testbench for serial_ck: directed vectors, a frame-level reference model,
// and literal spot checks.
module tb_serial_ck;

  logic        clk;
  logic        rst;
  logic [31:0] cnt;
  logic        y0;
  logic [7:0]  ncyc;
  logic [31:0] n0, n1, n2;
  logic        ack;
  logic        y;

  int n_tests = 0;
  int n_fail  = 0;
  logic check_en = 1'b0;

  // Reference model state: the frame position as a plain integer.
  int          m_ph   = 0;
  logic [31:0] m_prev = '0;
  logic        m_ack  = 1'b0;

  // Literal y patterns indexed by phase.
  logic [15:0] y_tab_a;
  logic [15:0] y_tab_b;

  serial_ck dut (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .y0   (y0),
    .ncyc (ncyc),
    .n0   (n0),
    .n1   (n1),
    .n2   (n2),
    .ack  (ack),
    .y    (y)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // y is y0 flipped once for every threshold the phase has reached.
  function automatic logic model_y();
    int flips;
    logic [31:0] thr [3];
    thr[0] = n0; thr[1] = n1; thr[2] = n2;
    flips = 0;
    for (int k = 0; k < 3; k++)
      if (longint'(m_ph) >= longint'(thr[k])) flips++;
    return y0 ^ (flips % 2 == 1);
  endfunction

  // Frame bookkeeping, evaluated on the same edge the DUT samples.
  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_prev = '0; m_ack = 1'b0;
    end else begin
      m_ack = 1'b0;
      if (cnt == 32'd0) begin
        m_ph = 0;
      end else if (cnt != m_prev) begin
        if (ncyc == 8'd0) begin
          m_ph = 0;
        end else if (m_ph + 1 >= int'(ncyc)) begin
          m_ph = 0; m_ack = 1'b1;
        end else begin
          m_ph = m_ph + 1;
        end
      end
      m_prev = cnt;
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      check("ack_vs_model", ack, m_ack);
      check("y_vs_model", y, model_y());
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input logic [31:0] v);
    cnt = v;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    y_tab_a = 16'h000B;  // n=2,3,4 y0=1: ph0,1 high, ph2 low, ph3 high, rest low
    y_tab_b = 16'h0009;  // n=1,3,4 y0=1: ph0 high, ph1-2 low, ph3 high, rest low

    rst = 1'b1; cnt = '0; y0 = 1'b1; ncyc = 8'd16;
    n0 = 32'd2; n1 = 32'd3; n2 = 32'd4;

    // Reset for 10 cycles.
    tick();
    check_en = 1'b1;
    repeat (9) tick();
    check("reset_y", y, 1'b1);
    check("reset_ack", ack, 1'b0);
    rst = 1'b0;

    // Idle with cnt held at 0.
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_y", y, 1'b1);
      check("idle_ack", ack, 1'b0);
    end

    // Count up by one per cycle across three frames and a bit more.
    for (int i = 1; i <= 50; i++) begin
      step_to(i);
      check("run_y", y, y_tab_a[i % 16]);
      check("run_ack", ack, (i % 16) == 0);
    end

    // Move the first threshold to 1 and restart the frame.
    n0 = 32'd1;
    step_to(0);
    for (int i = 1; i <= 20; i++) begin
      step_to(i);
      check("n0_1_y", y, y_tab_b[i % 16]);
    end

    // Hold cnt at 5, then return to 0.
    n0 = 32'd2;
    step_to(0);
    for (int i = 1; i <= 5; i++) step_to(i);
    repeat (3) begin
      tick();
      check("hold_y", y, 1'b0);
      check("hold_ack", ack, 1'b0);
    end
    step_to(0);
    check("restart_y", y, 1'b1);

    // Large jumps still count as a single step each.
    step_to(100);
    step_to(7);
    check("jump_y", y, 1'b0);

    // Count wrapping through 0 restarts the frame with no ack.
    step_to(32'hFFFF_FFFE);
    step_to(32'hFFFF_FFFF);
    step_to(32'h0000_0000);
    check("wrap_ack", ack, 1'b0);
    check("wrap_y", y, 1'b1);

    // Shorten the frame mid-way: the next step wraps.
    for (int i = 1; i <= 10; i++) step_to(i);
    ncyc = 8'd8;
    step_to(11);
    check("shrink_ack", ack, 1'b1);
    ncyc = 8'd1;
    step_to(12);
    check("ncyc1_ack_a", ack, 1'b1);
    step_to(13);
    check("ncyc1_ack_b", ack, 1'b1);

    // Equal thresholds and an out-of-frame threshold.
    ncyc = 8'd16; n0 = 32'd3; n1 = 32'd3; n2 = 32'd200;
    step_to(0);
    for (int i = 1; i <= 20; i++) step_to(i);

    // Reset mid-frame at phase 9.
    n0 = 32'd2; n1 = 32'd3; n2 = 32'd4;
    step_to(0);
    for (int i = 1; i <= 9; i++) step_to(i);
    rst = 1'b1;
    tick();
    check("midrst_y", y, 1'b1);
    check("midrst_ack", ack, 1'b0);
    rst = 1'b0;
    for (int i = 10; i <= 30; i++) step_to(i);

    // Disabled frame: ph stays 0, no ack.
    ncyc = 8'd0; y0 = 1'b0; n0 = 32'd0; n1 = 32'd5; n2 = 32'd6;
    for (int i = 31; i <= 70; i++) begin
      step_to(i);
      check("dis_ack", ack, 1'b0);
      check("dis_y", y, 1'b1);
    end

    // Short randomised stretch, checked by the model only.
    for (int i = 0; i < 200; i++) begin
      ncyc = 8'($urandom_range(0, 12));
      n0   = $urandom_range(0, 12);
      n1   = $urandom_range(0, 12);
      n2   = $urandom_range(0, 12);
      y0   = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 3) != 0) cnt = cnt + $urandom_range(0, 3);
      if ($urandom_range(0, 30) == 0) cnt = '0;
      tick();
    end
    rst = 1'b0;
    tick();

    @(negedge clk);
    #1;
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
